// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared definitions for the register destination scoreboard: destination
// mode encoding, default geometry and the pending-counter width helper.
package reg_dest_scoreboard_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_PIPE_DEPTH = 3;
  localparam int DEFAULT_LINK_REG   = 31;

  // Destination select encoding presented by decode/control.
  typedef enum logic [1:0] {
    DST_RT      = 2'b00,
    DST_RD      = 2'b01,
    DST_LINK    = 2'b10,
    DST_ILLEGAL = 2'b11
  } dst_mode_e;

  // A register can have at most depth writes in flight, so the counter must
  // hold the values 0..depth.
  function automatic int pend_cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_dest_scoreboard_dst_select.sv
// Combinational destination mux: picks rt, rd or the link register from the
// decoded destination mode and flags the reserved encoding.
module reg_dest_scoreboard_dst_select
  import reg_dest_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int LINK_REG   = DEFAULT_LINK_REG
) (
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [1:0]            dst_mode,
  output logic [REG_ADDR_W-1:0] dst,
  output logic                  illegal
);

  // Mode to address decode; the reserved mode selects nothing and raises illegal.
  always_comb begin
    // NOTE: defaults first so every path assigns dst/illegal and no latch is inferred.
    dst     = '0;
    illegal = 1'b0;
    case (dst_mode)
      DST_RT:      dst     = rt;
      DST_RD:      dst     = rd;
      DST_LINK:    dst     = REG_ADDR_W'(LINK_REG);
      DST_ILLEGAL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Register destination scoreboard: selects the write destination of each
// issued instruction, carries it through a fixed-latency in-flight pipeline to
// the register file write port, and counts pending writes per register so
// decode can be stalled on a read-after-write hazard.
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W,
  parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  parameter int LINK_REG   = DEFAULT_LINK_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [1:0]            dst_mode,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  src_a_used,
  input  logic                  src_b_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  illegal_dst
);

  localparam int CNT_W = pend_cnt_width(PIPE_DEPTH);

  logic [REG_ADDR_W-1:0] sel_dst;
  logic                  sel_illegal;
  logic                  accept;
  logic                  entry_valid;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;

  // Stage 0 is filled at the accept edge; the last stage is the wb stage.
  logic                  stage_valid [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] stage_addr  [PIPE_DEPTH];
  logic [CNT_W-1:0]      pend_cnt    [NUM_REGS];

  reg_dest_scoreboard_dst_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .LINK_REG   (LINK_REG)
  ) u_dst_select (
    .rt       (rt),
    .rd       (rd),
    .dst_mode (dst_mode),
    .dst      (sel_dst),
    .illegal  (sel_illegal)
  );

  // Busy map from the pending counters; register 0 is hardwired and never busy.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (pend_cnt[r] != '0);
    end
  end

  // A stalled issue is not accepted; its own destination plays no part in the hazard.
  assign stall = issue_valid & ((src_a_used & busy[src_a]) | (src_b_used & busy[src_b]));
  assign accept      = issue_valid & ~stall & ~flush;
  assign entry_valid = accept & reg_write & ~sel_illegal & (sel_dst != '0);

  // One-hot increment (new entry) and decrement (entry leaving the wb stage).
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (entry_valid) inc_vec = NUM_REGS'(1) << sel_dst;
    if (wb_valid)    dec_vec = NUM_REGS'(1) << wb_addr;
  end

  // In-flight shift pipeline: advances every cycle, bubbles where nothing was accepted.
  always_ff @(posedge clk) begin
    // NOTE: the stage array is reset because its valid bits are control state;
    // a pure data array would be left unreset.
    if (rst || flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stage_valid[i] <= 1'b0;
        stage_addr[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking <= so every stage samples its neighbour's pre-edge value.
      stage_valid[0] <= entry_valid;
      stage_addr[0]  <= entry_valid ? sel_dst : '0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_addr[i]  <= stage_addr[i-1];
      end
    end
  end

  // Pending-write counters: +1 on entry, -1 after the wb cycle, net zero when both hit.
  // Flush clears everything; the wb write visible this cycle still completes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < NUM_REGS; r++) pend_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
      end
    end
  end

  // One-cycle pulse for an accepted issue carrying the reserved destination mode.
  always_ff @(posedge clk) begin
    if (rst) illegal_dst <= 1'b0;
    else     illegal_dst <= accept & sel_illegal;
  end

  assign wb_valid = stage_valid[PIPE_DEPTH-1];
  assign wb_addr  = stage_addr[PIPE_DEPTH-1];
  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard: a table of single-issue vectors for
// destination selection, then hand-written sequences for stall, duplicates,
// flush, simultaneous entry/retire and mid-flight reset.
module tb_reg_dest_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  rt, rd, src_a, src_b;
  logic [1:0]  dst_mode;
  logic        reg_write, src_a_used, src_b_used, flush;
  logic        stall, wb_valid, illegal_dst;
  logic [4:0]  wb_addr;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  reg_dest_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .rt          (rt),
    .rd          (rd),
    .dst_mode    (dst_mode),
    .reg_write   (reg_write),
    .src_a       (src_a),
    .src_b       (src_b),
    .src_a_used  (src_a_used),
    .src_b_used  (src_b_used),
    .flush       (flush),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy_vec    (busy_vec),
    .illegal_dst (illegal_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0] rt;
    logic [4:0] rd;
    logic [1:0] mode;
    logic       rw;
    logic       exp_wb;
    logic [4:0] exp_addr;
    logic       exp_ill;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    rt = '0; rd = '0; dst_mode = 2'b00; reg_write = 1'b0;
    src_a = '0; src_b = '0; src_a_used = 1'b0; src_b_used = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue_w(input logic [4:0] dst);
    idle();
    issue_valid = 1'b1;
    rt = dst; dst_mode = 2'b00; reg_write = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_busy;

    vecs[0] = '{rt: 5'd8,  rd: 5'd9,  mode: 2'b00, rw: 1'b1, exp_wb: 1'b1, exp_addr: 5'd8,  exp_ill: 1'b0};
    vecs[1] = '{rt: 5'd8,  rd: 5'd9,  mode: 2'b01, rw: 1'b1, exp_wb: 1'b1, exp_addr: 5'd9,  exp_ill: 1'b0};
    vecs[2] = '{rt: 5'd8,  rd: 5'd9,  mode: 2'b10, rw: 1'b1, exp_wb: 1'b1, exp_addr: 5'd31, exp_ill: 1'b0};
    vecs[3] = '{rt: 5'd8,  rd: 5'd9,  mode: 2'b11, rw: 1'b1, exp_wb: 1'b0, exp_addr: 5'd0,  exp_ill: 1'b1};
    vecs[4] = '{rt: 5'd8,  rd: 5'd9,  mode: 2'b00, rw: 1'b0, exp_wb: 1'b0, exp_addr: 5'd0,  exp_ill: 1'b0};
    vecs[5] = '{rt: 5'd0,  rd: 5'd9,  mode: 2'b00, rw: 1'b1, exp_wb: 1'b0, exp_addr: 5'd0,  exp_ill: 1'b0};
    vecs[6] = '{rt: 5'd12, rd: 5'd0,  mode: 2'b01, rw: 1'b1, exp_wb: 1'b0, exp_addr: 5'd0,  exp_ill: 1'b0};
    vecs[7] = '{rt: 5'd17, rd: 5'd22, mode: 2'b00, rw: 1'b1, exp_wb: 1'b1, exp_addr: 5'd17, exp_ill: 1'b0};

    // Reset held two cycles, with an issue on the inputs that must be ignored.
    idle();
    rst = 1'b1;
    issue_w(5'd4);
    tick();
    tick();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    check("rst_illegal", 32'(illegal_dst), 32'd0);
    idle();
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_no_wb_after", 32'(wb_valid), 32'd0);

    // Destination select vectors: one issue, then watch illegal, busy and wb.
    for (int i = 0; i < 8; i++) begin
      idle();
      issue_valid = 1'b1;
      rt = vecs[i].rt; rd = vecs[i].rd; dst_mode = vecs[i].mode; reg_write = vecs[i].rw;
      exp_busy = vecs[i].exp_wb ? (32'd1 << vecs[i].exp_addr) : 32'd0;
      tick();
      idle();
      check($sformatf("v%0d_illegal", i), 32'(illegal_dst), 32'(vecs[i].exp_ill));
      check($sformatf("v%0d_busy", i), busy_vec, exp_busy);
      check($sformatf("v%0d_wb_early", i), 32'(wb_valid), 32'd0);
      tick();
      check($sformatf("v%0d_illegal_gone", i), 32'(illegal_dst), 32'd0);
      tick();
      check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].exp_wb));
      if (vecs[i].exp_wb)
        check($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_busy_wb", i), busy_vec, exp_busy);
      tick();
      check($sformatf("v%0d_wb_done", i), 32'(wb_valid), 32'd0);
      check($sformatf("v%0d_busy_free", i), busy_vec, 32'd0);
    end

    // RAW stall: dest 5, then a reader of 5 that itself writes 11.
    issue_w(5'd5);
    tick();
    idle();
    issue_valid = 1'b1; rt = 5'd11; reg_write = 1'b1; src_a = 5'd5; src_a_used = 1'b1;
    #1;
    check("raw_stall_1", 32'(stall), 32'd1);
    check("raw_stalled_no_inc", busy_vec, 32'h0000_0020);
    tick();
    check("raw_stall_2", 32'(stall), 32'd1);
    tick();
    check("raw_stall_3", 32'(stall), 32'd1);
    check("raw_wb_valid", 32'(wb_valid), 32'd1);
    check("raw_wb_addr", 32'(wb_addr), 32'd5);
    tick();
    check("raw_stall_4", 32'(stall), 32'd0);
    check("raw_busy_free", busy_vec, 32'd0);
    tick();
    idle();
    check("raw_accepted_busy", busy_vec, 32'h0000_0800);
    tick();
    tick();
    check("raw_second_wb", 32'(wb_valid), 32'd1);
    check("raw_second_addr", 32'(wb_addr), 32'd11);
    tick();

    // Source-used gating, src_b path, no-issue and own-dest-as-source.
    issue_w(5'd5);
    tick();
    idle();
    issue_valid = 1'b1; src_a = 5'd5; src_a_used = 1'b0; src_b_used = 1'b1;
    #1;
    check("unused_src_no_stall", 32'(stall), 32'd0);
    src_b = 5'd5;
    #1;
    check("src_b_stall", 32'(stall), 32'd1);
    issue_valid = 1'b0;
    #1;
    check("no_issue_no_stall", 32'(stall), 32'd0);
    idle();
    issue_valid = 1'b1; rt = 5'd6; reg_write = 1'b1; src_a = 5'd6; src_a_used = 1'b1;
    #1;
    check("own_dest_no_stall", 32'(stall), 32'd0);
    tick();
    idle();
    check("own_dest_busy", busy_vec, 32'h0000_0060);
    for (int k = 0; k < 3; k++) tick();
    check("own_dest_drained", busy_vec, 32'd0);

    // Duplicate back-to-back writes to register 7.
    issue_w(5'd7);
    tick();
    issue_w(5'd7);
    tick();
    idle();
    check("dup_busy_1", busy_vec, 32'h0000_0080);
    tick();
    check("dup_wb1", 32'(wb_valid), 32'd1);
    check("dup_wb1_addr", 32'(wb_addr), 32'd7);
    check("dup_busy_2", busy_vec, 32'h0000_0080);
    tick();
    check("dup_wb2", 32'(wb_valid), 32'd1);
    check("dup_busy_3", busy_vec, 32'h0000_0080);
    tick();
    check("dup_busy_free", busy_vec, 32'd0);
    check("dup_wb_done", 32'(wb_valid), 32'd0);

    // Flush after dests 3, 4, 6; a concurrent issue of 9 must be dropped.
    issue_w(5'd3);
    tick();
    issue_w(5'd4);
    tick();
    issue_w(5'd6);
    tick();
    issue_w(5'd9);
    flush = 1'b1;
    #1;
    check("flush_wb3_valid", 32'(wb_valid), 32'd1);
    check("flush_wb3_addr", 32'(wb_addr), 32'd3);
    check("flush_busy_before", busy_vec, 32'h0000_0058);
    tick();
    idle();
    check("flush_busy_after", busy_vec, 32'd0);
    check("flush_no_wb4", 32'(wb_valid), 32'd0);
    tick();
    check("flush_no_wb6", 32'(wb_valid), 32'd0);
    tick();
    check("flush_no_wb9", 32'(wb_valid), 32'd0);
    check("flush_busy_end", busy_vec, 32'd0);

    // New write to 10 accepted during 10's own wb cycle.
    issue_w(5'd10);
    tick();
    idle();
    tick();
    tick();
    check("sim_wb1", 32'(wb_valid), 32'd1);
    check("sim_wb1_addr", 32'(wb_addr), 32'd10);
    issue_w(5'd10);
    tick();
    idle();
    check("sim_busy_held", busy_vec, 32'h0000_0400);
    check("sim_gap", 32'(wb_valid), 32'd0);
    tick();
    tick();
    check("sim_wb2", 32'(wb_valid), 32'd1);
    check("sim_wb2_addr", 32'(wb_addr), 32'd10);
    check("sim_busy_wb2", busy_vec, 32'h0000_0400);
    tick();
    check("sim_busy_free", busy_vec, 32'd0);

    // Reset mid-flight overrides the pending entries and a concurrent issue.
    issue_w(5'd13);
    tick();
    issue_w(5'd14);
    tick();
    issue_w(5'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mid_rst_busy", busy_vec, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mid_rst_no_wb_%0d", k), 32'(wb_valid), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
